// File: rtl/ram_bank_arbiter.sv
// Two-requester arbiter in front of a single-port RAM bank: round-robin by default,
// with a lock that lets one requester keep the bank across consecutive accesses.
module ram_bank_arbiter #(
    parameter int ADDR_BIT = 3,
    parameter int DATA_BIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic                lock0,
    input  logic                lock1,
    input  logic [ADDR_BIT-1:0] addr0,
    input  logic [ADDR_BIT-1:0] addr1,
    input  logic [DATA_BIT-1:0] wdata0,
    input  logic [DATA_BIT-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [DATA_BIT-1:0] rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic                ram_re,
    output logic [ADDR_BIT-1:0] ram_addr_w,
    output logic [ADDR_BIT-1:0] ram_addr_r,
    output logic [DATA_BIT-1:0] ram_d_w,
    input  logic [DATA_BIT-1:0] ram_d_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       arb0, arb1;
    logic [1:0] rv_q;
    logic       sel_wr;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        arb0    = 1'b0;
        arb1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !ptr_q)) arb0 = 1'b1;
                else if (req1)                 arb1 = 1'b1;
                if (arb0) begin
                    ptr_d = 1'b1;
                    if (lock0) state_d = OWN0;
                end else if (arb1) begin
                    ptr_d = 1'b0;
                    if (lock1) state_d = OWN1;
                end
            end
            OWN0: begin
                arb0 = req0;
                if (!lock0) begin
                    state_d = IDLE;
                    ptr_d   = 1'b1;
                end
            end
            OWN1: begin
                arb1 = req1;
                if (!lock1) begin
                    state_d = IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are forced low while reset is held, without waiting for a clock.
    assign gnt0 = arb0 & rst_n;
    assign gnt1 = arb1 & rst_n;

    assign sel_wr     = gnt1 ? wr1 : wr0;
    assign ram_en     = gnt0 | gnt1;
    assign ram_we     = ram_en & sel_wr;
    assign ram_re     = ram_en & ~sel_wr;
    assign ram_addr_w = gnt1 ? addr1 : addr0;
    assign ram_addr_r = gnt1 ? addr1 : addr0;
    assign ram_d_w    = gnt1 ? wdata1 : wdata0;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            rv_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rv_q    <= {gnt1 & ~wr1, gnt0 & ~wr0};
        end
    end

    // The bank returns read data one cycle after the strobe, aligned with rv_q.
    assign rvalid0 = rv_q[0];
    assign rvalid1 = rv_q[1];
    assign rdata   = ram_d_r;

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Self-checking bench for ram_bank_arbiter: directed scenarios plus randomized traffic
// compared against an ownership/turn reference model and a reference memory.
module tb_ram_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, wr0, wr1, lock0, lock1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        ram_en, ram_we, ram_re;
    logic [2:0]  ram_addr_w, ram_addr_r;
    logic [15:0] ram_d_w;
    logic [15:0] ram_d_r;

    ram_bank_arbiter #(.ADDR_BIT(3), .DATA_BIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_re(ram_re),
        .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r),
        .ram_d_w(ram_d_w), .ram_d_r(ram_d_r)
    );

    always #5 clk = ~clk;

    // Attached RAM bank: synchronous write, registered read.
    logic [15:0] bank [8];
    always @(posedge clk) begin
        if (ram_en && ram_we) bank[ram_addr_w] <= ram_d_w;
        if (ram_en && ram_re) ram_d_r <= bank[ram_addr_r];
    end

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: who owns the bank (-1 = nobody), whose turn it is, expected read returns.
    int          owner;
    int          turn;
    int          last_win;
    logic        exp_rv0, exp_rv1;
    logic [15:0] exp_rdata;
    logic [15:0] ref_mem [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        turn    = 0;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
    endtask

    // One clock cycle: inputs already driven; check outputs, then advance the model.
    task automatic tick();
        int          win;
        logic        w_wr, w_lock;
        logic [2:0]  w_addr;
        logic [15:0] w_data;
        #1;
        if (owner >= 0)         win = ((owner == 0) ? req0 : req1) ? owner : -1;
        else if (req0 && req1)  win = turn;
        else if (req0)          win = 0;
        else if (req1)          win = 1;
        else                    win = -1;
        w_wr   = (win == 1) ? wr1 : wr0;
        w_lock = (win == 1) ? lock1 : lock0;
        w_addr = (win == 1) ? addr1 : addr0;
        w_data = (win == 1) ? wdata1 : wdata0;

        check("gnt0", gnt0, win == 0);
        check("gnt1", gnt1, win == 1);
        check("ram_en", ram_en, win >= 0);
        check("ram_we", ram_we, win >= 0 && w_wr);
        check("ram_re", ram_re, win >= 0 && !w_wr);
        if (win >= 0) begin
            check("ram_addr_w", ram_addr_w, w_addr);
            check("ram_addr_r", ram_addr_r, w_addr);
            check("ram_d_w", ram_d_w, w_data);
        end
        check("rvalid0", rvalid0, exp_rv0);
        check("rvalid1", rvalid1, exp_rv1);
        if (exp_rv0 || exp_rv1) check("rdata", rdata, exp_rdata);

        @(posedge clk);
        exp_rv0 = (win == 0) && !w_wr;
        exp_rv1 = (win == 1) && !w_wr;
        if (win >= 0 && !w_wr) exp_rdata = ref_mem[w_addr];
        if (win >= 0 && w_wr)  ref_mem[w_addr] = w_data;
        if (owner >= 0) begin
            if (!((owner == 0) ? lock0 : lock1)) begin
                turn  = 1 - owner;
                owner = -1;
            end
        end else if (win >= 0) begin
            turn = 1 - win;
            if (w_lock) owner = win;
        end
        last_win = win;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        {req0, req1, wr0, wr1, lock0, lock1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        model_reset();
        last_win = -1;

        // Reset values
        @(negedge clk);
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_re", ram_re, 1'b0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Initialise every bank location through requester 1 writes
        for (int a = 0; a < 8; a++) begin
            req1 = 1'b1; wr1 = 1'b1; addr1 = 3'(a); wdata1 = 16'(16'h1000 + a * 16'h0111);
            tick();
        end
        req1 = 1'b0;

        // Both requesting continuously: grants alternate, requester 0 first after reset
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd2;
        for (int i = 0; i < 6; i++) tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Write 0xBEEF to 5 from requester 0, then read 5 from requester 1
        req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd5; wdata0 = 16'hBEEF;
        tick();
        req0 = 1'b0;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd5;
        tick();
        req1 = 1'b0;
        tick();
        check("beef_rdata", rdata, 16'hBEEF);
        tick();

        // Locked burst of 3 from requester 0 while requester 1 waits
        req0 = 1'b1; wr0 = 1'b0; lock0 = 1'b1;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd6; wdata1 = 16'h6666;
        for (int i = 0; i < 3; i++) begin
            addr0 = 3'(i);
            tick();
        end
        req0 = 1'b0; lock0 = 1'b0;
        tick();
        tick();
        req1 = 1'b0;
        tick();

        // Preload 0..3 then four back-to-back reads from requester 0
        for (int a = 0; a < 4; a++) begin
            req0 = 1'b1; wr0 = 1'b1; addr0 = 3'(a); wdata0 = 16'(16'hA000 + a * 16'h0123);
            tick();
        end
        wr0 = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr0 = 3'(a);
            tick();
        end
        req0 = 1'b0;
        tick();

        // Randomized traffic; a requester holds its fields until granted
        for (int i = 0; i < 400; i++) begin
            if (!req0) begin
                req0 = ($urandom_range(0, 2) != 0); wr0 = 1'($urandom);
                addr0 = 3'($urandom); wdata0 = 16'($urandom);
            end
            if (!req1) begin
                req1 = ($urandom_range(0, 2) != 0); wr1 = 1'($urandom);
                addr1 = 3'($urandom); wdata1 = 16'($urandom);
            end
            lock0 = ($urandom_range(0, 2) == 0);
            lock1 = ($urandom_range(0, 2) == 0);
            tick();
            if (last_win == 0) req0 = 1'b0;
            if (last_win == 1) req1 = 1'b0;
        end
        {req0, req1, lock0, lock1} = '0;
        tick();
        tick();

        // Reset pulsed during a read grant: strobes drop at once, no rvalid follows
        req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd2;
        #1;
        check("pre_rst_gnt0", gnt0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt0", gnt0, 1'b0);
        check("mid_rst_ram_en", ram_en, 1'b0);
        check("mid_rst_ram_re", ram_re, 1'b0);
        @(posedge clk);
        #1;
        check("post_edge_rvalid0", rvalid0, 1'b0);
        check("post_edge_rvalid1", rvalid1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd3;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd4;
        tick();
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
